pipe_stage_buf: RTL and testbench

//  Parametrised pipeline-stage register, successor to the fixed per-stage latches
//  (IF/ID, ID/EX, EX/MEM, MEM/WB). Holds DEPTH entries of DATA_W payload plus halt flag.

---
 rtl/pipe_stage_buf.sv | 178 +++++++++++++++++
 tb/tb_pipe_stage_buf.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_buf.sv
// -----------------------------------------------------------------------------
// pipe_stage_buf
//
// Parametrised pipeline-stage register that replaces the fixed per-stage
// latches (IF/ID, ID/EX, EX/MEM, MEM/WB). It holds up to DEPTH entries, each
// made of an opaque DATA_W payload and a halt flag, and moves them with a
// valid/ready handshake. It also has a global stage enable (stall), a
// synchronous flush and a sticky halt indicator.
//
//   DEPTH = 1   : classic stage latch. in_ready depends on out_ready whenever
//                 the latch is occupied.
//   DEPTH >= 2  : skid buffer. A downstream stall is absorbed by the spare
//                 entries, so upstream does not see a combinational stall
//                 chain in the common case.
//
// Parameters
//   DATA_W      payload width in bits
//   DEPTH       number of entries, 1..4
//   BUBBLE_VAL  value shown on out_data while out_valid = 0
//
// Ports
//   CLK         clock, all state updates on the rising edge
//   nRST        synchronous active-low reset, wins over flush and enable
//   enable      stage enable; 0 freezes storage, count, pointers and halt
//   flush       drop every stored entry and any push in the same cycle
//   in_valid    upstream offers an entry
//   in_ready    buffer accepts the offered entry this cycle
//   in_data     upstream payload
//   in_halt     upstream entry carries halt
//   out_valid   head entry is valid
//   out_ready   downstream consumes the head this cycle
//   out_data    head payload, BUBBLE_VAL when empty
//   out_halt    head halt flag, 0 when empty
//   halt        sticky: an entry with halt set has been consumed
//   count       number of occupied entries
// -----------------------------------------------------------------------------
module pipe_stage_buf #(
    parameter int                DATA_W     = 32,
    parameter int                DEPTH      = 2,
    parameter logic [DATA_W-1:0] BUBBLE_VAL = '0
) (
    input  logic                         CLK,
    input  logic                         nRST,
    input  logic                         enable,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [DATA_W-1:0]            in_data,
    input  logic                         in_halt,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DATA_W-1:0]            out_data,
    output logic                         out_halt,
    output logic                         halt,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    // Entry storage. Not reset: contents are only ever observed through
    // rd_ptr while count is non-zero, and count is reset.
    logic [DATA_W-1:0] ent_data [DEPTH];
    logic              ent_halt [DEPTH];

    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr_nxt;
    logic [PTR_W-1:0]  wr_ptr_nxt;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_nxt;
    logic              halt_q;
    logic              halt_nxt;

    logic              full;
    logic              empty;
    logic              push;
    logic              pop;
    logic              head_halt;

    // Pointers wrap explicitly so that non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == LAST_PTR) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

    // -------------------------------------------------------------------------
    // Handshake
    // -------------------------------------------------------------------------
    assign full  = (cnt_q == FULL_CNT);
    assign empty = (cnt_q == '0);

    // out_ready reaches in_ready only when full: a pop frees the slot that the
    // same-edge push is written into.
    assign in_ready = enable & ~flush & (~full | out_ready);

    assign push = in_valid & in_ready;
    assign pop  = ~empty & out_ready & enable;

    // -------------------------------------------------------------------------
    // Head presentation (no bypass: a pushed entry shows up after the edge)
    // -------------------------------------------------------------------------
    assign out_valid = ~empty;
    assign head_halt = ent_halt[rd_ptr];

    always_comb begin
        out_data = BUBBLE_VAL;
        out_halt = 1'b0;
        if (!empty) begin
            out_data = ent_data[rd_ptr];
            out_halt = head_halt;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state
    // -------------------------------------------------------------------------
    always_comb begin
        cnt_nxt    = cnt_q;
        rd_ptr_nxt = rd_ptr;
        wr_ptr_nxt = wr_ptr;

        if (flush) begin
            // Flush beats push and pop, independent of enable.
            cnt_nxt    = '0;
            rd_ptr_nxt = '0;
            wr_ptr_nxt = '0;
        end else begin
            if (push) begin
                wr_ptr_nxt = ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr_nxt = ptr_inc(rd_ptr);
            end
            unique case ({push, pop})
                2'b10:   cnt_nxt = cnt_q + 1'b1;
                2'b01:   cnt_nxt = cnt_q - 1'b1;
                default: cnt_nxt = cnt_q;
            endcase
        end
    end

    // A head discarded by a flush in the same cycle does not count as consumed.
    assign halt_nxt = halt_q | (pop & head_halt & ~flush);

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            cnt_q  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            halt_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_nxt;
            rd_ptr <= rd_ptr_nxt;
            wr_ptr <= wr_ptr_nxt;
            halt_q <= halt_nxt;
        end
    end

    always_ff @(posedge CLK) begin
        if (nRST && push) begin
            ent_data[wr_ptr] <= in_data;
            ent_halt[wr_ptr] <= in_halt;
        end
    end

    assign halt  = halt_q;
    assign count = cnt_q;

endmodule

// File: tb/tb_pipe_stage_buf.sv
// -----------------------------------------------------------------------------
// tb_pipe_stage_buf
//
// Three instances (DEPTH 2, 1, 3) share the control inputs; in_valid is routed
// only to the instance under test (sel). The driver applies directed vectors
// and states whether each offered entry must be accepted; the monitor turns
// that into an expected-entry queue and checks the head presented by the
// selected DUT every cycle.
// -----------------------------------------------------------------------------
module tb_pipe_stage_buf;

    localparam logic [31:0] BUB = 32'hDEAD_BEEF;

    typedef struct packed {
        logic [31:0] data;
        logic        halt;
    } ent_t;

    logic        clk = 1'b0;
    logic        nrst;
    logic        enable;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_halt;
    logic        out_ready;

    logic        exp_acc;
    logic        mon_on;
    int          sel;

    int          n_chk;
    int          n_fail;
    ent_t        exp_q[$];

    logic        iv   [3];
    logic        rdy  [3];
    logic        ov   [3];
    logic [31:0] od   [3];
    logic        oh   [3];
    logic        hl   [3];
    logic [1:0]  cnt_d2;
    logic [0:0]  cnt_d1;
    logic [1:0]  cnt_d3;

    logic        s_in_ready;
    logic        s_out_valid;
    logic [31:0] s_out_data;
    logic        s_out_halt;
    logic        s_halt;
    int          s_count;

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            iv[i] = in_valid && (sel == i);
        end
    end

    always_comb begin
        s_in_ready  = rdy[0];
        s_out_valid = ov[0];
        s_out_data  = od[0];
        s_out_halt  = oh[0];
        s_halt      = hl[0];
        s_count     = int'(cnt_d2);
        if (sel == 1) begin
            s_in_ready  = rdy[1];
            s_out_valid = ov[1];
            s_out_data  = od[1];
            s_out_halt  = oh[1];
            s_halt      = hl[1];
            s_count     = int'(cnt_d1);
        end else if (sel == 2) begin
            s_in_ready  = rdy[2];
            s_out_valid = ov[2];
            s_out_data  = od[2];
            s_out_halt  = oh[2];
            s_halt      = hl[2];
            s_count     = int'(cnt_d3);
        end
    end

    pipe_stage_buf #(.DATA_W(32), .DEPTH(2), .BUBBLE_VAL(BUB)) u_d2 (
        .CLK(clk), .nRST(nrst), .enable(enable), .flush(flush),
        .in_valid(iv[0]), .in_ready(rdy[0]), .in_data(in_data), .in_halt(in_halt),
        .out_valid(ov[0]), .out_ready(out_ready), .out_data(od[0]), .out_halt(oh[0]),
        .halt(hl[0]), .count(cnt_d2)
    );

    pipe_stage_buf #(.DATA_W(32), .DEPTH(1), .BUBBLE_VAL(BUB)) u_d1 (
        .CLK(clk), .nRST(nrst), .enable(enable), .flush(flush),
        .in_valid(iv[1]), .in_ready(rdy[1]), .in_data(in_data), .in_halt(in_halt),
        .out_valid(ov[1]), .out_ready(out_ready), .out_data(od[1]), .out_halt(oh[1]),
        .halt(hl[1]), .count(cnt_d1)
    );

    pipe_stage_buf #(.DATA_W(32), .DEPTH(3), .BUBBLE_VAL(BUB)) u_d3 (
        .CLK(clk), .nRST(nrst), .enable(enable), .flush(flush),
        .in_valid(iv[2]), .in_ready(rdy[2]), .in_data(in_data), .in_halt(in_halt),
        .out_valid(ov[2]), .out_ready(out_ready), .out_data(od[2]), .out_halt(oh[2]),
        .halt(hl[2]), .count(cnt_d3)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (sel=%0d t=%0t): got 0x%0h, expected 0x%0h",
                     name, sel, $time, act, exp);
        end
    endtask

    // Monitor / scoreboard: runs mid-cycle, after the driver has settled.
    always @(negedge clk) begin
        if (mon_on) begin
            chk("out_valid", 64'(s_out_valid), 64'(exp_q.size() != 0));
            if (exp_q.size() != 0) begin
                chk("out_data", 64'(s_out_data), 64'(exp_q[0].data));
                chk("out_halt", 64'(s_out_halt), 64'(exp_q[0].halt));
            end else begin
                chk("bubble_data", 64'(s_out_data), 64'(BUB));
                chk("bubble_halt", 64'(s_out_halt), 64'd0);
            end
            if (in_valid) begin
                chk("in_ready", 64'(s_in_ready), 64'(exp_acc));
            end
            if (flush) begin
                exp_q.delete();
            end else begin
                if (out_ready && enable && exp_q.size() != 0) begin
                    void'(exp_q.pop_front());
                end
                if (in_valid && exp_acc) begin
                    exp_q.push_back({in_data, in_halt});
                end
            end
        end
    end

    task automatic drive(input logic v, input logic [31:0] d, input logic h,
                         input logic ordy, input logic en, input logic fl,
                         input logic acc);
        in_valid  = v;
        in_data   = d;
        in_halt   = h;
        out_ready = ordy;
        enable    = en;
        flush     = fl;
        exp_acc   = acc;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_count(input string name, input int exp);
        chk(name, 64'(s_count), 64'(exp));
    endtask

    task automatic do_flush();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        tick();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        mon_on = 1'b0;
        sel    = 0;
        nrst   = 1'b0;
        drive(1'b1, 32'h99, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);

        // 1: reset with in_valid held high
        tick();
        tick();
        for (int i = 0; i < 3; i++) begin
            sel = i;
            #1;
            chk_count("rst_count", 0);
            chk("rst_out_valid", 64'(s_out_valid), 64'd0);
            chk("rst_out_data", 64'(s_out_data), 64'(BUB));
            chk("rst_halt", 64'(s_halt), 64'd0);
        end
        sel = 0;
        drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        nrst   = 1'b1;
        mon_on = 1'b1;
        tick();

        // 2: streaming, DEPTH=2
        drive(1'b1, 32'h11, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        tick();
        chk_count("stream_cnt1", 1);
        chk("stream_d1", 64'(s_out_data), 64'h11);
        drive(1'b1, 32'h22, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        tick();
        chk_count("stream_cnt2", 1);
        chk("stream_d2", 64'(s_out_data), 64'h22);
        drive(1'b1, 32'h33, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        tick();
        chk_count("stream_cnt3", 1);
        chk("stream_d3", 64'(s_out_data), 64'h33);
        drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        chk_count("stream_drain", 0);

        // 3: skid / full
        drive(1'b1, 32'hA, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        tick();
        drive(1'b1, 32'hB, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        tick();
        chk_count("full_cnt", 2);
        drive(1'b1, 32'hC, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        #1;
        chk("full_in_ready", 64'(s_in_ready), 64'd0);
        tick();
        chk_count("full_hold", 2);
        drive(1'b1, 32'hC, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        #1;
        chk("full_ready_via_out", 64'(s_in_ready), 64'd1);
        tick();
        chk_count("full_pushpop", 2);
        chk("full_head_b", 64'(s_out_data), 64'hB);

        // 4: flush beats a pending push
        drive(1'b1, 32'hD, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        tick();
        chk_count("flush_cnt", 0);
        chk("flush_valid", 64'(s_out_valid), 64'd0);
        drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        chk_count("flush_d_absent", 0);

        // 5: stall
        drive(1'b1, 32'h51, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        tick();
        drive(1'b1, 32'h52, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        tick();
        drive(1'b1, 32'h53, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk_count("stall_cnt", 2);
            chk("stall_head", 64'(s_out_data), 64'h51);
            chk("stall_in_ready", 64'(s_in_ready), 64'd0);
        end
        drive(1'b1, 32'h53, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        tick();
        chk("resume_head", 64'(s_out_data), 64'h52);
        drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        chk("resume_last", 64'(s_out_data), 64'h53);
        tick();
        chk_count("resume_empty", 0);

        // 6: halt, DEPTH=2
        drive(1'b1, 32'h5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        tick();
        chk("halt_pre", 64'(s_halt), 64'd0);
        chk("halt_head_flag", 64'(s_out_halt), 64'd1);
        drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        chk("halt_set", 64'(s_halt), 64'd1);
        do_flush();
        #1;
        chk("halt_after_flush", 64'(s_halt), 64'd1);

        // DEPTH=1
        sel = 1;
        drive(1'b1, 32'h61, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        tick();
        chk_count("d1_cnt", 1);
        drive(1'b1, 32'h62, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        #1;
        chk("d1_full_ready", 64'(s_in_ready), 64'd0);
        tick();
        drive(1'b1, 32'h62, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        tick();
        chk("d1_head", 64'(s_out_data), 64'h62);
        drive(1'b1, 32'h5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        tick();
        chk("d1_halt_pre", 64'(s_halt), 64'd0);
        drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        chk("d1_halt_set", 64'(s_halt), 64'd1);
        chk_count("d1_empty", 0);
        do_flush();
        #1;
        chk("d1_halt_flush", 64'(s_halt), 64'd1);

        // DEPTH=3: a head discarded by flush must not set halt
        sel = 2;
        drive(1'b1, 32'h5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        tick();
        drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        tick();
        chk("d3_flush_pop_no_halt", 64'(s_halt), 64'd0);
        chk_count("d3_flushed", 0);

        // DEPTH=3: 7 pushes, pointers wrap
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 32'h70 + 32'(k), 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
            tick();
        end
        chk_count("d3_full", 3);
        drive(1'b1, 32'h73, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        #1;
        chk("d3_full_ready", 64'(s_in_ready), 64'd0);
        for (int k = 3; k < 7; k++) begin
            drive(1'b1, 32'h70 + 32'(k), 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
            tick();
            chk_count("d3_pushpop_full", 3);
        end
        drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        tick();
        tick();
        chk_count("d3_drained", 0);

        drive(1'b1, 32'h5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        tick();
        drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        chk("d3_halt_set", 64'(s_halt), 64'd1);
        do_flush();
        #1;
        chk("d3_halt_flush", 64'(s_halt), 64'd1);
        chk("sb_empty", 64'(exp_q.size()), 64'd0);

        tick();
        mon_on = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
